text_overlay: RTL and testbench

TEXT_OVERLAY -- requirements
Module: text_overlay

---
 rtl/text_overlay_pkg.sv | 8 +
 rtl/text_overlay_channel.sv | 47 ++++
 rtl/text_overlay.sv | 104 ++++++++++
 tb/tb_text_overlay.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: shared font geometry constants and channel FSM encoding
package text_overlay_pkg;
  localparam int FONT_W = 8;
  localparam int ADDR_W = 11;
  localparam int BIT_W = 3;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_EXPIRED} ch_state_t;
endpackage

// File: rtl/text_overlay_channel.sv
// overlay_channel: per-channel trigger FSM with frame hold timer
module overlay_channel
  import text_overlay_pkg::*;
#(
  parameter int HOLD_FRAMES = 180
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pause,
  input  logic i_tick,
  input  logic i_en,
  output logic o_show
);
  localparam int HW = HOLD_FRAMES > 0 ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD = HW'(HOLD_FRAMES);
  ch_state_t r_state, w_state;
  logic [HW-1:0] r_cnt, w_cnt;
  logic r_arm;
  logic w_rise, w_dec;
  // r_arm stays low after reset until ch_en is seen low, so a held-high enable never triggers
  assign w_rise = i_en & r_arm;
  assign w_dec = i_tick & ~i_pause & (HOLD_FRAMES != 0);
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    if (!i_en) w_state = ST_IDLE;
    else if (w_rise) begin
      w_state = ST_SHOW;
      w_cnt = HOLD;
    end else if (r_state == ST_SHOW && w_dec) begin
      w_cnt = r_cnt - 1'b1;
      if (r_cnt == HW'(1)) w_state = ST_EXPIRED;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_arm <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_arm <= ~i_en;
    end
  end
  assign o_show = r_state == ST_SHOW;
endmodule

// File: rtl/text_overlay.sv
// text_overlay: priority-muxed multi-channel text overlay with two-stage font pipeline
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HOLD_FRAMES = 180,
  parameter int BLINK_FRAMES = 30,
  parameter logic [NUM_CH-1:0] OPAQUE_MASK = 4'b0001,
  parameter logic [NUM_CH-1:0] BLINK_MASK = 4'b0000,
  parameter logic [NUM_CH*RGB_W-1:0] FG_RGB = {12'h501, 12'h501, 12'h501, 12'h001},
  parameter logic [RGB_W-1:0] BG_RGB = 12'h110
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic                     refresh_tick,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_on,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rom_addr,
  input  logic [NUM_CH*BIT_W-1:0]  ch_bit_addr,
  output logic [ADDR_W-1:0]        font_addr,
  input  logic [FONT_W-1:0]        font_word,
  output logic                     text_on,
  output logic [RGB_W-1:0]         text_rgb
);
  localparam int WW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [NUM_CH-1:0] w_show, w_vis;
  logic [BW-1:0] r_blink;
  logic r_phase, w_wrap;
  logic w_hit, w_fbit, w_opq;
  logic [WW-1:0] w_win, r_win;
  logic [BIT_W-1:0] w_bit, r_bit;
  logic [RGB_W-1:0] w_fg;
  logic r_vld;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    overlay_channel #(.HOLD_FRAMES(HOLD_FRAMES)) u_ch (
      .clk(clk),
      .reset(reset),
      .i_pause(pause),
      .i_tick(refresh_tick),
      .i_en(ch_en[i]),
      .o_show(w_show[i])
    );
  end
  assign w_wrap = r_blink == BW'(BLINK_FRAMES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink <= '0;
      r_phase <= 1'b1;
    end else if (refresh_tick & ~pause) begin
      r_blink <= w_wrap ? '0 : r_blink + 1'b1;
      r_phase <= w_wrap ? ~r_phase : r_phase;
    end
  end
  assign w_vis = w_show & (~BLINK_MASK | {NUM_CH{r_phase}});
  // descending scan so the lowest-index hit is assigned last and wins
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_bit = '0;
    font_addr = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_on[i] & w_vis[i]) begin
        w_hit = 1'b1;
        w_win = WW'(i);
        w_bit = ch_bit_addr[i*BIT_W +: BIT_W];
        font_addr = ch_rom_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_win <= '0;
      r_bit <= '0;
    end else begin
      r_vld <= w_hit;
      r_win <= w_win;
      r_bit <= w_bit;
    end
  end
  // column 0 is the glyph MSB, so 7 - bit_addr reduces to the bitwise complement
  assign w_fbit = font_word[~r_bit];
  always_comb begin
    w_fg = '0;
    w_opq = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_win == WW'(i)) begin
        w_fg = FG_RGB[i*RGB_W +: RGB_W];
        w_opq = OPAQUE_MASK[i];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_on <= 1'b0;
      text_rgb <= '0;
    end else begin
      text_on <= r_vld & (w_fbit | w_opq);
      text_rgb <= !r_vld ? '0 : w_fbit ? w_fg : w_opq ? BG_RGB : '0;
    end
  end
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: randomized scoreboard bench against a frame-level reference model
module tb_text_overlay;
  localparam int HOLD = 3;
  localparam int BF = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic refresh_tick = 1'b0;
  logic [3:0] ch_en = '0;
  logic [3:0] ch_on = '0;
  logic [43:0] ch_rom_addr = '0;
  logic [11:0] ch_bit_addr = '0;
  logic [10:0] font_addr;
  logic [7:0] font_word = '0;
  logic text_on;
  logic [11:0] text_rgb;
  typedef struct {int cyc; logic on; logic [11:0] rgb;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit m_show[4];
  bit m_low[4];
  int m_left[4];
  int m_ticks;
  text_overlay #(
    .NUM_CH(4), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BF),
    .OPAQUE_MASK(4'b0001), .BLINK_MASK(4'b0100),
    .FG_RGB({12'h501, 12'h501, 12'h501, 12'h001}), .BG_RGB(12'h110)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .refresh_tick(refresh_tick),
    .ch_en(ch_en), .ch_on(ch_on), .ch_rom_addr(ch_rom_addr), .ch_bit_addr(ch_bit_addr),
    .font_addr(font_addr), .font_word(font_word), .text_on(text_on), .text_rgb(text_rgb)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [7:0] rom(input logic [10:0] a);
    logic [15:0] t;
    t = {5'd0, a} * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction
  always @(posedge clk) font_word <= rom(font_addr);
  function automatic logic [2:0] pick(input logic [10:0] a, input logic want);
    logic [7:0] fw;
    fw = rom(a);
    for (int j = 0; j < 8; j++) if (fw[7-j] == want) return 3'(j);
    return 3'd0;
  endfunction
  function automatic bit visible(input int i);
    return m_show[i] && (i != 2 || ((m_ticks / BF) % 2) == 0);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_show[i] = 0;
      m_low[i] = 0;
      m_left[i] = 0;
    end
    m_ticks = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc - 2) begin
      e = q.pop_front();
      total++;
      if (text_on !== e.on || text_rgb !== e.rgb) begin
        bad++;
        $display("FAIL pixel issued@%0d: got on=%b rgb=%h, want on=%b rgb=%h", e.cyc, text_on, text_rgb, e.on, e.rgb);
      end
    end
  end
  task automatic step(input logic [3:0] en, input logic [3:0] on, input logic tk, input logic ps,
                      input logic [43:0] ad, input logic [11:0] bt);
    int w, col;
    logic [7:0] fw;
    logic b, opq;
    logic [10:0] ea;
    exp_t e;
    @(negedge clk);
    ch_en = en; ch_on = on; refresh_tick = tk; pause = ps; ch_rom_addr = ad; ch_bit_addr = bt;
    w = -1;
    for (int i = 3; i >= 0; i--) if (on[i] && visible(i)) w = i;
    e.cyc = cyc;
    ea = '0;
    if (w < 0) begin
      e.on = 1'b0;
      e.rgb = 12'h000;
    end else begin
      ea = ad[w*11 +: 11];
      fw = rom(ea);
      col = int'(bt[w*3 +: 3]);
      b = fw[7-col];
      opq = (w == 0);
      e.on = b | opq;
      e.rgb = b ? ((w == 0) ? 12'h001 : 12'h501) : opq ? 12'h110 : 12'h000;
    end
    q.push_back(e);
    #1;
    total++;
    if (font_addr !== ea) begin
      bad++;
      $display("FAIL font_addr@%0d: got %h, want %h", e.cyc, font_addr, ea);
    end
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) m_show[i] = 0;
      else if (m_low[i]) begin
        m_show[i] = 1;
        m_left[i] = HOLD;
      end else if (m_show[i] && tk && !ps && HOLD > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) m_show[i] = 0;
      end
      m_low[i] = !en[i];
    end
    if (tk && !ps) m_ticks++;
  endtask
  function automatic logic [43:0] rand_addrs();
    logic [43:0] r;
    for (int i = 0; i < 4; i++) r[i*11 +: 11] = 11'($urandom);
    return r;
  endfunction
  task automatic check_reset_outputs(input string tag);
    total++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000) begin
      bad++;
      $display("FAIL %s: got on=%b rgb=%h, want on=0 rgb=000", tag, text_on, text_rgb);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask
  initial begin
    logic [43:0] ad;
    logic [11:0] bt;
    logic [3:0] ren;
    model_reset();
    #1;
    check_reset_outputs("reset_state");
    total++;
    if (font_addr !== 11'd0) begin
      bad++;
      $display("FAIL reset_font_addr: got %h, want 000", font_addr);
    end
    do_reset();
    ad = rand_addrs();
    bt = '0;
    bt[5:3] = pick(ad[21:11], 1'b1);
    repeat (3) step(4'b0000, 4'b0010, 1'b0, 1'b0, ad, bt);
    for (int k = 0; k < 15; k++) step(4'b0010, 4'b0010, (k % 3) == 2, 1'b0, ad, bt);
    step(4'b0000, 4'b0010, 1'b0, 1'b0, ad, bt);
    repeat (6) step(4'b0010, 4'b0010, 1'b0, 1'b0, ad, bt);
    step(4'b0000, 4'b0011, 1'b0, 1'b0, ad, bt);
    ad = rand_addrs();
    bt[2:0] = pick(ad[10:0], 1'b1);
    bt[5:3] = pick(ad[21:11], 1'b1);
    repeat (4) step(4'b0011, 4'b0011, 1'b0, 1'b0, ad, bt);
    bt[2:0] = pick(ad[10:0], 1'b0);
    repeat (3) step(4'b0011, 4'b0001, 1'b0, 1'b0, ad, bt);
    step(4'b0000, 4'b0100, 1'b0, 1'b0, ad, bt);
    bt[8:6] = pick(ad[32:22], 1'b0);
    repeat (3) step(4'b0100, 4'b0100, 1'b0, 1'b0, ad, bt);
    bt[8:6] = pick(ad[32:22], 1'b1);
    for (int k = 0; k < 24; k++)
      step((k % 4) == 3 ? 4'b0000 : 4'b0100, 4'b0100, (k % 2) == 0, 1'b0, ad, bt);
    for (int k = 0; k < 8; k++)
      step((k % 4) == 3 ? 4'b0000 : 4'b0100, 4'b0100, 1'b1, 1'b1, ad, bt);
    step(4'b0000, 4'b0001, 1'b0, 1'b0, ad, bt);
    for (int k = 0; k < 8; k++) step(4'b0001, 4'b0001, 1'b0, 1'b0, ad, {9'd0, 3'(k)});
    ren = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) ren[i] = ~ren[i];
      step(ren, 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           rand_addrs(), 12'($urandom));
    end
    ad = rand_addrs();
    step(4'b0000, 4'b0001, 1'b0, 1'b0, ad, 12'($urandom));
    repeat (4) step(4'b0001, 4'b0001, 1'b0, 1'b0, ad, 12'($urandom));
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_show");
    q.delete();
    model_reset();
    do_reset();
    repeat (8) step(4'b0001, 4'b0001, 1'b1, 1'b0, ad, 12'($urandom));
    step(4'b0000, 4'b0001, 1'b0, 1'b0, ad, 12'($urandom));
    repeat (4) step(4'b0001, 4'b0001, 1'b0, 1'b0, ad, 12'($urandom));
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) ren[i] = ~ren[i];
      step(ren, 4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           rand_addrs(), 12'($urandom));
    end
    repeat (4) @(negedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
